// File: rtl/sata_oob.sv
// Host SATA OOB sequencer: COMRESET/COMWAKE exchange, D10.2/ALIGN handshake, link-up; no backpressure.
// All outputs registered (1-cycle latency); optional o_debug status word when SATA_OOB_DEBUG_EN is defined.
module sata_oob #(
   parameter logic [19:0] COMINIT_TIMEOUT = 20'd750_000,
   parameter logic [16:0] ALIGN_TIMEOUT   = 17'd65_535,
   parameter logic [7:0]  CALIB_CYCLES    = 8'd100,
   parameter logic [3:0]  RETRY_LIMIT     = 4'd8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_phy_ready,
   output logic        o_tx_cominit,
   output logic        o_tx_comwake,
   input  logic        i_tx_comfinish,
   input  logic        i_rx_cominit,
   input  logic        i_rx_comwake,
   output logic        o_tx_elecidle,
   output logic [1:0]  o_tx_mode,
   input  logic        i_rx_valid,
   input  logic [31:0] i_rx_data,
   input  logic [3:0]  i_rx_ctrl,
   output logic        o_link_up,
`ifdef SATA_OOB_DEBUG_EN
   output logic [31:0] o_debug,
`endif
   output logic        o_err
);

   localparam logic [31:0] ALIGN_PRIM = 32'h7B4A_4ABC;

   typedef enum logic [3:0] {
      S_IDLE           = 4'd0,
      S_COMRESET       = 4'd1,
      S_WAIT_COMINIT   = 4'd2,
      S_WAIT_CINIT_END = 4'd3,
      S_CALIB          = 4'd4,
      S_COMWAKE        = 4'd5,
      S_WAIT_COMWAKE   = 4'd6,
      S_WAIT_WAKE_END  = 4'd7,
      S_SEND_D10       = 4'd8,
      S_SEND_ALIGN     = 4'd9,
      S_READY          = 4'd10,
      S_FAILED         = 4'd11
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [19:0] r_cnt;
   logic [19:0] w_cnt_next;
   logic [3:0]  r_retry;
   logic [3:0]  w_retry_next;
   logic [3:0]  w_retry_inc;
   logic [1:0]  r_na_cnt;
   logic [1:0]  w_na_next;
   logic        w_align;
   logic        w_nonalign;
   logic        w_timeout;
   logic        w_retry_req;
   logic        w_tx_cominit;
   logic        w_tx_comwake;
   logic        w_tx_elecidle;
   logic [1:0]  w_tx_mode;
   logic        w_link_up;
   logic        w_err;

   assign w_align     = i_rx_valid && (i_rx_data == ALIGN_PRIM) && (i_rx_ctrl == 4'b0001);
   assign w_nonalign  = i_rx_valid && i_rx_ctrl[0] && !w_align;
   assign w_timeout   = (r_cnt == 20'd0);
   assign w_retry_inc = r_retry + 4'd1;

   always_comb begin
      w_next       = r_state;
      w_retry_next = r_retry;
      w_na_next    = r_na_cnt;
      w_retry_req  = 1'b0;

      // Advancing events are tested before the timeout so they win a tie.
      case (r_state)
         S_IDLE:           if (i_phy_ready) w_next = S_COMRESET;
         S_COMRESET:       if (i_tx_comfinish) w_next = S_WAIT_COMINIT;
         S_WAIT_COMINIT: begin
            if (i_rx_cominit)   w_next = S_WAIT_CINIT_END;
            else if (w_timeout) w_retry_req = 1'b1;
         end
         S_WAIT_CINIT_END: if (!i_rx_cominit) w_next = S_CALIB;
         S_CALIB:          if (w_timeout) w_next = S_COMWAKE;
         S_COMWAKE:        if (i_tx_comfinish) w_next = S_WAIT_COMWAKE;
         S_WAIT_COMWAKE: begin
            if (i_rx_comwake)   w_next = S_WAIT_WAKE_END;
            else if (w_timeout) w_retry_req = 1'b1;
         end
         S_WAIT_WAKE_END:  if (!i_rx_comwake) w_next = S_SEND_D10;
         S_SEND_D10: begin
            if (w_align) begin
               w_next    = S_SEND_ALIGN;
               w_na_next = 2'd0;
            end else if (w_timeout) begin
               w_retry_req = 1'b1;
            end
         end
         S_SEND_ALIGN: begin
            if (w_align) begin
               w_na_next = 2'd0;
            end else if (w_nonalign) begin
               if (r_na_cnt == 2'd2) w_next = S_READY;
               else                  w_na_next = r_na_cnt + 2'd1;
            end
         end
         S_READY: begin
            w_retry_next = 4'd0;
            if (i_rx_cominit) w_next = S_COMRESET;
         end
         S_FAILED:         w_next = S_FAILED;
         default:          w_next = S_IDLE;
      endcase

      if (w_retry_req) begin
         w_retry_next = w_retry_inc;
         w_next       = (w_retry_inc == RETRY_LIMIT) ? S_FAILED : S_COMRESET;
      end

      if (!i_phy_ready) begin
         w_next       = S_IDLE;
         w_retry_next = 4'd0;
         w_na_next    = 2'd0;
      end

      // One shared timer: reloaded on entry to a timed state, otherwise counts down to 0.
      w_cnt_next = (r_cnt != 20'd0) ? (r_cnt - 20'd1) : 20'd0;
      if (w_next != r_state) begin
         case (w_next)
            S_WAIT_COMINIT: w_cnt_next = COMINIT_TIMEOUT;
            S_CALIB:        w_cnt_next = {12'd0, CALIB_CYCLES};
            S_WAIT_COMWAKE: w_cnt_next = {3'd0, ALIGN_TIMEOUT};
            default:        w_cnt_next = w_cnt_next;
         endcase
      end

      w_tx_cominit  = (w_next == S_COMRESET) && (r_state != S_COMRESET);
      w_tx_comwake  = (w_next == S_COMWAKE) && (r_state != S_COMWAKE);
      w_tx_elecidle = !(w_next inside {S_SEND_D10, S_SEND_ALIGN, S_READY});
      w_link_up     = (w_next == S_READY);
      w_err         = (w_next == S_FAILED);
      case (w_next)
         S_SEND_D10:   w_tx_mode = 2'd1;
         S_SEND_ALIGN: w_tx_mode = 2'd2;
         S_READY:      w_tx_mode = 2'd3;
         default:      w_tx_mode = 2'd0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= 20'd0;
         r_retry       <= 4'd0;
         r_na_cnt      <= 2'd0;
         o_tx_cominit  <= 1'b0;
         o_tx_comwake  <= 1'b0;
         o_tx_elecidle <= 1'b1;
         o_tx_mode     <= 2'd0;
         o_link_up     <= 1'b0;
         o_err         <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_cnt         <= w_cnt_next;
         r_retry       <= w_retry_next;
         r_na_cnt      <= w_na_next;
         o_tx_cominit  <= w_tx_cominit;
         o_tx_comwake  <= w_tx_comwake;
         o_tx_elecidle <= w_tx_elecidle;
         o_tx_mode     <= w_tx_mode;
         o_link_up     <= w_link_up;
         o_err         <= w_err;
      end
   end

`ifdef SATA_OOB_DEBUG_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_debug <= 32'd0;
      end else begin
         o_debug <= {w_cnt_next[17:0], w_err, w_link_up, i_rx_comwake, i_rx_cominit,
                     w_na_next, w_retry_next, w_next};
      end
   end
`endif

endmodule

// File: tb/tb_sata_oob.sv
// Randomized scoreboard bench for sata_oob: driver predicts output change events, monitor pops and compares.
`timescale 1ns/1ps
module tb_sata_oob;

   localparam int CI  = 1000;
   localparam int AL  = 500;
   localparam int CAL = 10;
   localparam logic [31:0] ALIGN_W = 32'h7B4A_4ABC;
   localparam logic [31:0] SYNC_W  = 32'hB5B5_957C;

   // Output vector: {cominit, comwake, elecidle, mode[1:0], link_up, err}
   localparam logic [6:0] V_IDLE = 7'b0_0_1_00_0_0;
   localparam logic [6:0] V_CI   = 7'b1_0_1_00_0_0;
   localparam logic [6:0] V_CW   = 7'b0_1_1_00_0_0;
   localparam logic [6:0] V_D10  = 7'b0_0_0_01_0_0;
   localparam logic [6:0] V_AL   = 7'b0_0_0_10_0_0;
   localparam logic [6:0] V_RDY  = 7'b0_0_0_11_1_0;
   localparam logic [6:0] V_FAIL = 7'b0_0_1_00_0_1;

   localparam int K_IDLE = 0, K_DATA = 1, K_FAKE = 2, K_NEAR = 3, K_ALIGN = 4, K_SYNC = 5, K_PRIM = 6;

   logic        clk = 1'b0;
   logic        reset, phy_ready, comfinish, rx_cominit, rx_comwake, rx_valid;
   logic [31:0] rx_data;
   logic [3:0]  rx_ctrl;
   logic        tx_cominit, tx_comwake, tx_elecidle, link_up, err;
   logic [1:0]  tx_mode;
`ifdef SATA_OOB_DEBUG_EN
   logic [31:0] debug;
`endif

   sata_oob #(
      .COMINIT_TIMEOUT(20'd1000),
      .ALIGN_TIMEOUT  (17'd500),
      .CALIB_CYCLES   (8'd10),
      .RETRY_LIMIT    (4'd3)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_phy_ready   (phy_ready),
      .o_tx_cominit  (tx_cominit),
      .o_tx_comwake  (tx_comwake),
      .i_tx_comfinish(comfinish),
      .i_rx_cominit  (rx_cominit),
      .i_rx_comwake  (rx_comwake),
      .o_tx_elecidle (tx_elecidle),
      .o_tx_mode     (tx_mode),
      .i_rx_valid    (rx_valid),
      .i_rx_data     (rx_data),
      .i_rx_ctrl     (rx_ctrl),
      .o_link_up     (link_up),
`ifdef SATA_OOB_DEBUG_EN
      .o_debug       (debug),
`endif
      .o_err         (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [6:0] v;
   } ev_t;

   ev_t        exp_q[$];
   logic [6:0] mv;
   int         errors = 0;
   int         checks = 0;
   bit         mon_en = 1'b0;
   bit         first = 1'b1;
   logic [6:0] prev;
   logic [6:0] cur;
   ev_t        got_e;
   int         m_phase;
   int         m_run;

   // Monitor: every change of the output vector must match the next predicted event.
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         cur = {tx_cominit, tx_comwake, tx_elecidle, tx_mode, link_up, err};
         if (first || cur != prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cyc=%0d got=%b required=no change (prev %b)", cyc, cur, prev);
            end else begin
               got_e = exp_q.pop_front();
               if (got_e.c != cyc || got_e.v != cur) begin
                  errors++;
                  $display("FAIL output_event cyc=%0d got=%b required cyc=%0d vec=%b", cyc, cur, got_e.c, got_e.v);
               end
            end
            prev  = cur;
            first = 1'b0;
         end
      end
   end

   task automatic exp_set(input int c, input logic [6:0] v);
      ev_t e;
      if (v != mv) begin
         if (exp_q.size() > 0 && exp_q[$].c == c) begin
            e   = exp_q.pop_back();
            e.v = v;
         end else begin
            e.c = c;
            e.v = v;
         end
         exp_q.push_back(e);
         mv = v;
      end
   endtask

   task automatic exp_pulse_ci(input int c);
      exp_set(c, V_CI);
      exp_set(c + 1, V_IDLE);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse_finish();
      comfinish = 1'b1;
      step();
      comfinish = 1'b0;
   endtask

   // Burst completion some cycles after the COMRESET pulse seen at pc; p is the drive cycle.
   task automatic finish_comreset(input int pc, output int p);
      p = pc + $urandom_range(2, 25);
      wait_until(p);
      pulse_finish();
   endtask

   // WAIT_COMINIT entered at p+1; COMINIT driven at p+d. Returns the predicted COMWAKE pulse cycle.
   task automatic cominit_exchange(input int p, input int d, output int cwc);
      int h;
      wait_until(p + 2);
      pulse_finish();
      wait_until(p + d);
      rx_cominit = 1'b1;
      h = $urandom_range(5, 40);
      wait_until(p + d + h);
      rx_cominit = 1'b0;
      cwc = p + d + h + CAL + 2;
      exp_set(cwc, V_CW);
      exp_set(cwc + 1, V_IDLE);
   endtask

   // Returns s (comfinish drive cycle, ALIGN timer loaded at s+1); leaves driver in SEND_D10.
   task automatic comwake_exchange(input int cwc, output int s);
      int d, h, u;
      s = cwc + $urandom_range(2, 25);
      wait_until(s);
      pulse_finish();
      d = $urandom_range(3, 40);
      wait_until(s + d);
      rx_comwake = 1'b1;
      h = $urandom_range(3, 30);
      wait_until(s + d + h);
      rx_comwake = 1'b0;
      u = s + d + h;
      exp_set(u + 1, V_D10);
      step();
      m_phase = 0;
      m_run   = 0;
   endtask

   function automatic int pick_kind();
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) return K_IDLE;
      if (r < 30) return K_DATA;
      if (r < 35) return K_FAKE;
      if (r < 42) return K_NEAR;
      if (r < 57) return K_ALIGN;
      if (r < 82) return K_SYNC;
      return K_PRIM;
   endfunction

   // Drives one RX word and applies the handshake rules: ALIGN restarts the run,
   // other valid K-words extend it, non-K words leave it alone; third in a row links up.
   task automatic send_word(input int kind);
      bit is_al, is_prim;
      rx_valid = 1'b1;
      rx_ctrl  = 4'b0001;
      rx_data  = SYNC_W;
      is_al    = 1'b0;
      is_prim  = 1'b1;
      case (kind)
         K_IDLE: begin
            rx_valid = 1'b0; rx_data = $urandom; rx_ctrl = 4'($urandom); is_prim = 1'b0;
         end
         K_DATA: begin
            rx_data = $urandom; rx_ctrl = {3'($urandom), 1'b0}; is_prim = 1'b0;
         end
         K_FAKE: begin
            rx_valid = 1'b0; rx_data = ALIGN_W; is_prim = 1'b0;
         end
         K_NEAR:  rx_ctrl = 4'b0011;
         K_ALIGN: begin
            rx_data = ALIGN_W; is_al = 1'b1;
         end
         K_PRIM: begin
            rx_data = $urandom;
            if (rx_data == ALIGN_W) rx_data = SYNC_W;
            rx_ctrl = {3'($urandom), 1'b1};
         end
         default: rx_data = SYNC_W;
      endcase
      if (m_phase == 0 && is_al) begin
         m_phase = 1;
         m_run   = 0;
         exp_set(cyc + 1, V_AL);
      end else if (m_phase == 1) begin
         if (is_al) begin
            m_run = 0;
         end else if (is_prim) begin
            m_run++;
            if (m_run == 3) begin
               m_phase = 2;
               exp_set(cyc + 1, V_RDY);
            end
         end
      end
      step();
      rx_valid = 1'b0;
   endtask

   task automatic run_to_ready();
      for (int i = 0; m_phase != 2; i++) begin
         if (i < 60)            send_word(pick_kind());
         else if (m_phase == 0) send_word(K_ALIGN);
         else                   send_word(K_SYNC);
      end
   endtask

   task automatic device_reset(output int pc);
      rx_cominit = 1'b1;
      pc = cyc + 1;
      exp_pulse_ci(pc);
      step();
      step();
      rx_cominit = 1'b0;
   endtask

   // An attempt where the device never answers; last selects FAILED instead of a new COMRESET.
   task automatic no_cominit_attempt(input int pc, input bit last, output int npc);
      int p;
      finish_comreset(pc, p);
      wait_until(p + 5);
      pulse_finish();
      npc = p + CI + 2;
      if (last) exp_set(npc, V_FAIL);
      else      exp_pulse_ci(npc);
      wait_until(npc);
   endtask

   initial begin
      int pc, p, cwc, s, y, k;
      reset = 1'b1; phy_ready = 1'b0; comfinish = 1'b0; rx_cominit = 1'b0;
      rx_comwake = 1'b0; rx_valid = 1'b0; rx_data = 32'd0; rx_ctrl = 4'd0;
      prev = 7'd0; cur = 7'd0; mv = 7'h7F; m_phase = 0; m_run = 0;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      exp_set(cyc + 1, V_IDLE);
      step();

      // Happy path
      reset = 1'b0; phy_ready = 1'b1;
      pc = cyc + 1;
      exp_pulse_ci(pc);
      finish_comreset(pc, p);
      cominit_exchange(p, $urandom_range(4, 60), cwc);
      comwake_exchange(cwc, s);
      send_word(K_DATA); send_word(K_NEAR);
      send_word(K_ALIGN); send_word(K_ALIGN);
      send_word(K_SYNC); send_word(K_SYNC); send_word(K_SYNC);
      repeat (5) send_word(pick_kind());

      // Device reset in READY, then an interrupted ALIGN run
      device_reset(pc);
      finish_comreset(pc, p);
      cominit_exchange(p, $urandom_range(4, 60), cwc);
      comwake_exchange(cwc, s);
      send_word(K_SYNC); send_word(K_FAKE); send_word(K_ALIGN);
      send_word(K_SYNC); send_word(K_SYNC); send_word(K_ALIGN);
      send_word(K_SYNC); send_word(K_SYNC);
      send_word(K_IDLE); send_word(K_DATA); send_word(K_FAKE);
      send_word(K_SYNC);
      repeat (4) send_word(pick_kind());

      // Random RX streams
      for (int r = 0; r < 3; r++) begin
         device_reset(pc);
         finish_comreset(pc, p);
         cominit_exchange(p, $urandom_range(4, 60), cwc);
         comwake_exchange(cwc, s);
         run_to_ready();
         repeat (6) send_word(pick_kind());
      end

      // ALIGN timeout, then two unanswered attempts exhaust the retries
      device_reset(pc);
      finish_comreset(pc, p);
      cominit_exchange(p, $urandom_range(4, 60), cwc);
      comwake_exchange(cwc, s);
      for (int i = 0; i < 8; i++) begin
         k = pick_kind();
         if (k == K_ALIGN) k = K_NEAR;
         send_word(k);
      end
      pc = s + AL + 2;
      exp_pulse_ci(pc);
      wait_until(pc);
      no_cominit_attempt(pc, 1'b0, p);
      no_cominit_attempt(p, 1'b1, pc);
      wait_until(pc + 10);
      pulse_finish();
      wait_until(pc + 60);

      // Reset while FAILED, then a fresh run of three unanswered attempts
      reset = 1'b1;
      exp_set(cyc + 1, V_IDLE);
      step();
      step();
      reset = 1'b0;
      pc = cyc + 1;
      exp_pulse_ci(pc);
      no_cominit_attempt(pc, 1'b0, p);
      no_cominit_attempt(p, 1'b0, pc);
      no_cominit_attempt(pc, 1'b1, p);
      wait_until(p + 30);

      // PHY drop while FAILED
      phy_ready = 1'b0;
      y = cyc;
      exp_set(y + 1, V_IDLE);
      wait_until(y + 3);
      phy_ready = 1'b1;
      pc = y + 4;
      exp_pulse_ci(pc);

      // COMINIT arrives exactly as the timer expires: the event must win
      finish_comreset(pc, p);
      cominit_exchange(p, CI + 1, cwc);
      comwake_exchange(cwc, s);
      repeat (4) send_word(K_SYNC);

      // PHY drop mid SEND_D10
      phy_ready = 1'b0;
      exp_set(cyc + 1, V_IDLE);
      repeat (30) step();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events got=%0d outstanding required=0 (next cyc=%0d vec=%b)",
                  exp_q.size(), exp_q[0].c, exp_q[0].v);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sata_oob.md
Name: sata_oob

Overview:
- Host-side SATA out-of-band (OOB) sequencer and link-bring-up controller.
- Sits directly downstream of the PHY init sequencer and takes that block's completion flag as i_phy_ready.
- Drives the GTX COMRESET/COMWAKE requests and transmit electrical idle.
- Performs the D10.2 / ALIGN handshake with the device and asserts o_link_up when the link layer may take over TX/RX.

Parameters:
- COMINIT_TIMEOUT, 20'd750_000, i_clk cycles to wait for device COMINIT before reissuing COMRESET (10 ms at 75 MHz).
- ALIGN_TIMEOUT, 17'd65_535, i_clk cycles to wait for device ALIGN after COMWAKE exchange (≈874 µs at 75 MHz).
- CALIB_CYCLES, 8'd100, i_clk cycles of quiet (elec-idle) after COMINIT ends, before COMWAKE.
- RETRY_LIMIT, 4'd8, consecutive failed attempts before o_err.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_phy_ready  in  1  PHY init complete; low forces IDLE
- o_tx_cominit  out  1  one-cycle request for GTX COMRESET burst
- o_tx_comwake  out  1  one-cycle request for GTX COMWAKE burst
- i_tx_comfinish  in  1  GTX reports OOB burst finished (one-cycle pulse)
- i_rx_cominit  in  1  device COMINIT detected (level, synchronised upstream)
- i_rx_comwake  in  1  device COMWAKE detected (level)
- o_tx_elecidle  out  1  transmit electrical idle
- o_tx_mode  out  2  0 = idle, 1 = D10.2, 2 = ALIGN, 3 = link-layer pass-through
- i_rx_valid  in  1  RX word valid (byte-aligned, decoded)
- i_rx_data  in  32  RX decoded word
- i_rx_ctrl  in  4  RX K-character flags
- o_link_up  out  1  link established
- o_err  out  1  retry limit exhausted

Behaviour:
- Interface: reset is i_reset, synchronous, active-high; clock is i_clk.
- Reset values: o_tx_elecidle = 1, o_tx_mode = 0, o_tx_cominit = 0, o_tx_comwake = 0, o_link_up = 0, o_err = 0; state IDLE; retry counter 0.
- ALIGN is i_rx_valid && i_rx_data == 32'h7B4A_4ABC && i_rx_ctrl == 4'b0001.
- Non-ALIGN primitive is i_rx_valid && i_rx_ctrl[0] && !ALIGN.
- Single down-counter (20 bits) serves all timeouts.
  - It is loaded on state entry and saturates at 0.
  - Timeout fires on the cycle the counter reads 0 while in a timed state.
- States and transitions:
  - IDLE: elecidle = 1. On i_phy_ready → COMRESET.
  - COMRESET: pulse o_tx_cominit on the entry cycle only. On i_tx_comfinish → WAIT_COMINIT, counter ← COMINIT_TIMEOUT.
  - WAIT_COMINIT: on i_rx_cominit → WAIT_CINIT_END. On timeout → retry (see below).
  - WAIT_CINIT_END: wait for i_rx_cominit low, then → CALIB, counter ← CALIB_CYCLES.
  - CALIB: at 0 → COMWAKE.
  - COMWAKE: pulse o_tx_comwake on entry. On i_tx_comfinish → WAIT_COMWAKE, counter ← ALIGN_TIMEOUT.
  - WAIT_COMWAKE: on i_rx_comwake → WAIT_WAKE_END. On timeout → retry.
  - WAIT_WAKE_END: on i_rx_comwake low → SEND_D10. The counter keeps running.
  - SEND_D10: elecidle = 0, mode = 1. On ALIGN → SEND_ALIGN. On timeout → retry.
  - SEND_ALIGN: mode = 2. Count consecutive non-ALIGN primitives (2-bit counter). It is cleared by any ALIGN and held on non-primitive words. On the 3rd → READY.
  - READY: mode = 3, o_link_up = 1, retry counter ← 0. On i_rx_cominit (device reset) → COMRESET, with o_link_up low in the same cycle as the transition.
  - FAILED: o_err = 1, elecidle = 1. Held until i_reset or !i_phy_ready.
- Retry: increment the retry counter. If it reaches RETRY_LIMIT → FAILED; else → COMRESET.
- !i_phy_ready in any state → IDLE next cycle. All outputs return to reset values; the retry counter clears.
- i_tx_comfinish outside COMRESET/COMWAKE is ignored.
- Simultaneous timeout and the advancing event in the same cycle: the event wins.
- OOB request pulses are exactly one cycle. They are never reissued while waiting for i_tx_comfinish.
- Output latency: all outputs are registered and change one cycle after the causing input.

Optional Feature:
- Macro: SATA_OOB_DEBUG_EN.
- Defined: adds port o_debug (out, 32), registered, updated every cycle.
  - [3:0] state
  - [7:4] retry count
  - [9:8] non-ALIGN count
  - [10] i_rx_cominit
  - [11] i_rx_comwake
  - [12] o_link_up
  - [13] o_err
  - [31:14] counter[17:0]
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Happy path, with COMINIT_TIMEOUT = 1000 and CALIB_CYCLES = 10. Stimulus: raise i_phy_ready; comfinish 20 cycles after o_tx_cominit; COMINIT high 30 cycles; COMWAKE after the wake pulse; ALIGN ×2; then SYNC 32'h B5B5_957C (ctrl 0001) ×3. Response: exactly one o_tx_cominit and one o_tx_comwake pulse; mode 0→1→2→3; o_link_up high one cycle after the 3rd SYNC.
- No COMINIT, with COMINIT_TIMEOUT = 1000 and RETRY_LIMIT = 3. Response: o_tx_cominit pulses at ~1000-cycle spacing, 3 pulses total; then o_err = 1, elecidle = 1, and no further pulses.
- ALIGN interruption. Stimulus: during SEND_ALIGN send SYNC, SYNC, ALIGN, SYNC, SYNC. Response: o_link_up stays 0 until a 3rd consecutive SYNC arrives.
- ALIGN timeout, with ALIGN_TIMEOUT = 500. Stimulus: no ALIGN after COMWAKE. Response: retry count becomes 1 and a new o_tx_cominit pulse is issued at ≈500 cycles.
- Device reset in READY. Stimulus: assert i_rx_cominit. Response: o_link_up falls next cycle, mode = 0, and an o_tx_cominit pulse follows.
- i_phy_ready drop mid-SEND_D10, and i_reset during FAILED. Response: next cycle all outputs are at reset values and o_err = 0.
